// File: rtl/seg_scan.sv
// Two-digit multiplexed 7-segment driver: clamps a binary countdown value, converts it
// to BCD with a one-iteration-per-cycle double-dabble, and scans tens/ones digits.
module seg_scan #(
    parameter int SCAN_DIV  = 50,
    parameter int CLAMP_MAX = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] num_in,
    input  logic       num_valid,
    input  logic       phase_in,
    output logic [7:0] seg_out,
    output logic [1:0] dig_sel,
    output logic       busy
);

    localparam int             CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [7:0]     CLAMP_V   = 8'(CLAMP_MAX);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t        state_q;
    logic          busy_q;
    logic [7:0]    bin_q;
    logic [7:0]    bcd_q;
    logic [3:0]    iter_q;
    logic [3:0]    tens_q;
    logic [3:0]    ones_q;

    logic [CW-1:0] scan_q;
    logic [CW-1:0] scan_d;
    logic          ones_act_q;
    logic          ones_act_d;
    logic          phase_q;
    logic [7:0]    seg_q;
    logic [7:0]    seg_d;
    logic [1:0]    dig_q;
    logic [1:0]    dig_d;

    logic [7:0]    num_clamped;
    logic [3:0]    tens_adj;
    logic [3:0]    ones_adj;
    logic [7:0]    bcd_step;
    logic [7:0]    bin_step;

    function automatic logic [7:0] seg_encode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // One double-dabble step: add 3 to any BCD nibble >= 5, then shift the binary MSB in.
    always_comb begin
        num_clamped = (num_in > CLAMP_V) ? CLAMP_V : num_in;
        tens_adj    = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
        ones_adj    = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
        bcd_step    = {tens_adj[2:0], ones_adj, bin_q[7]};
        bin_step    = {bin_q[6:0], 1'b0};
    end

    // A strobe always wins, so a strobe during CONV restarts from scratch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            bin_q   <= 8'd0;
            bcd_q   <= 8'd0;
            iter_q  <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
        end else if (num_valid) begin
            state_q <= CONV;
            busy_q  <= 1'b1;
            bin_q   <= num_clamped;
            bcd_q   <= 8'd0;
            iter_q  <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                end
                CONV: begin
                    if (iter_q == 4'd8) begin
                        tens_q  <= bcd_q[7:4];
                        ones_q  <= bcd_q[3:0];
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        bcd_q  <= bcd_step;
                        bin_q  <= bin_step;
                        iter_q <= iter_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Segments are computed for the digit that becomes active on the same edge as dig_sel.
    always_comb begin
        scan_d     = (scan_q == SCAN_LAST) ? '0 : scan_q + CW'(1);
        ones_act_d = (scan_q == SCAN_LAST) ? ~ones_act_q : ones_act_q;
        dig_d      = ones_act_d ? 2'b10 : 2'b01;
        if (ones_act_d) begin
            seg_d = seg_encode(ones_q) & (phase_q ? 8'h7F : 8'hFF);
        end else if (tens_q == 4'd0) begin
            seg_d = 8'hFF;
        end else begin
            seg_d = seg_encode(tens_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q     <= '0;
            ones_act_q <= 1'b1;
            phase_q    <= 1'b0;
            dig_q      <= 2'b10;
            seg_q      <= 8'hC0;
        end else begin
            scan_q     <= scan_d;
            ones_act_q <= ones_act_d;
            phase_q    <= phase_in;
            dig_q      <= dig_d;
            seg_q      <= seg_d;
        end
    end

    assign seg_out = seg_q;
    assign dig_sel = dig_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: a spec-level model schedules conversion completions into a queue;
// a negedge monitor pops them on busy falling and checks busy, scan period and segments.
module tb_seg_scan;

    localparam int SCAN_DIV  = 50;
    localparam int CLAMP_MAX = 99;
    localparam int LATENCY   = 9;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] num_in;
    logic       num_valid;
    logic       phase_in;
    logic [7:0] seg_out;
    logic [1:0] dig_sel;
    logic       busy;

    int compared   = 0;
    int mismatched = 0;

    // Model state: edge count, pending conversion, displayed value, phase, gating.
    int cyc         = 0;
    int pend_age    = -1;
    int pend_val    = 0;
    int shown       = 0;
    int model_phase = 0;
    int stable_from = 0;
    int scan_ref    = 0;
    logic [39:0] exp_q[$];

    logic       prev_busy = 1'b0;
    logic [1:0] prev_dig  = 2'b10;

    always #5 clk = ~clk;

    seg_scan #(.SCAN_DIV(SCAN_DIV), .CLAMP_MAX(CLAMP_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .num_in    (num_in),
        .num_valid (num_valid),
        .phase_in  (phase_in),
        .seg_out   (seg_out),
        .dig_sel   (dig_sel),
        .busy      (busy)
    );

    function automatic logic [7:0] enc(input int d);
        logic [7:0] tbl [0:9];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return tbl[d];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model evaluated on each rising edge from the sampled inputs.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            pend_age    = -1;
            shown       = 0;
            model_phase = 0;
            scan_ref    = cyc;
            stable_from = cyc + 1;
        end else begin
            if (int'(phase_in) != model_phase) stable_from = cyc + 1;
            model_phase = int'(phase_in);
            if (num_valid) begin
                pend_val = (int'(num_in) > CLAMP_MAX) ? CLAMP_MAX : int'(num_in);
                pend_age = 0;
            end else if (pend_age >= 0) begin
                pend_age++;
                if (pend_age == LATENCY) begin
                    shown       = pend_val;
                    pend_age    = -1;
                    stable_from = cyc + 1;
                    exp_q.push_back({cyc[31:0], pend_val[7:0]});
                end
            end
        end
    end

    // Monitor: samples on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        logic [39:0] e;
        logic [7:0]  exp_seg;
        if (rst) begin
            prev_busy = 1'b0;
            prev_dig  = dig_sel;
        end else begin
            check("busy_level", int'(busy), (pend_age >= 0) ? 1 : 0);
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_edge", cyc, int'(e[39:8]));
                end
            end
            check("dig_onehot", int'(dig_sel == 2'b10 || dig_sel == 2'b01), 1);
            if (dig_sel != prev_dig || cyc - scan_ref >= SCAN_DIV) begin
                check("scan_period", (dig_sel != prev_dig) ? cyc - scan_ref : -1, SCAN_DIV);
                scan_ref = cyc;
            end
            if (cyc >= stable_from) begin
                if (dig_sel == 2'b10)
                    exp_seg = enc(shown % 10) & ((model_phase != 0) ? 8'h7F : 8'hFF);
                else
                    exp_seg = (shown / 10 == 0) ? 8'hFF : enc(shown / 10);
                check(dig_sel == 2'b10 ? "seg_ones" : "seg_tens", int'(seg_out), int'(exp_seg));
            end
            prev_busy = busy;
            prev_dig  = dig_sel;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input int v);
        num_in    = 8'(v);
        num_valid = 1'b1;
        tick(1);
        num_valid = 1'b0;
    endtask

    initial begin
        int gap;
        rst       = 1'b1;
        num_in    = 8'd0;
        num_valid = 1'b0;
        phase_in  = 1'b0;
        tick(3);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_dig", int'(dig_sel), 2);
        check("rst_seg", int'(seg_out), 8'hC0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(120);

        strobe(29);  tick(110);
        strobe(7);   tick(110);
        strobe(150); tick(110);
        strobe(29);  tick(3);
        strobe(15);  tick(110);
        strobe(5);   tick(20);
        phase_in = 1'b1; tick(110);
        phase_in = 1'b0; tick(110);

        strobe(29); tick(3);
        rst = 1'b1;
        #1 check("rst_mid_busy", int'(busy), 0);
        tick(1);
        rst = 1'b0;
        tick(150);

        repeat (40) begin
            if ($urandom_range(0, 3) == 0) phase_in = ~phase_in;
            strobe(int'($urandom_range(0, 255)));
            gap = int'($urandom_range(0, 130));
            if (gap > 0) tick(gap);
        end
        phase_in = 1'b0;
        tick(150);

        for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick(1);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
